// File: rtl/fir_fsm.sv
// fir_fsm: control sequencer for one FIR filtering run.
// Drives the sample counter strobes, sweeps the coefficient taps for each
// sample, steers the MAC datapath and hands every result downstream with a
// valid/ready handshake. All outputs are registered from the next state.
module fir_fsm #(
  parameter int N_TAPS_MAX = 32,
  parameter int MAC_LAT    = 2
) (
  input  logic        clk_b,
  input  logic        rst_n,
  input  logic        start,
  input  logic [13:0] ile_probek,
  input  logic [5:0]  ile_wsp,
  input  logic [12:0] A_probki_FIR,
  input  logic        licznik_full,
  output logic        FSM_zapisz_probki,
  output logic        FSM_reset_licznik,
  output logic        FSM_nowa_probka,
  output logic [13:0] ile_probek_licznik,
  output logic [4:0]  A_wsp,
  output logic [12:0] A_x,
  output logic        mac_clear,
  output logic        mac_en,
  output logic        wynik_valid,
  input  logic        wynik_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_INIT    = 4'd1;
  localparam logic [3:0] S_MAC_CLR = 4'd2;
  localparam logic [3:0] S_MAC     = 4'd3;
  localparam logic [3:0] S_DRAIN   = 4'd4;
  localparam logic [3:0] S_WRITE   = 4'd5;
  localparam logic [3:0] S_NEXT    = 4'd6;
  localparam logic [3:0] S_CHECK   = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;

  localparam logic [13:0] N_MAX      = 14'd8192;
  localparam logic [5:0]  T_MAX      = 6'(N_TAPS_MAX);
  localparam logic [7:0]  DRAIN_LAST = 8'(MAC_LAT - 1);

  logic [3:0]  state_q, state_d;
  logic [4:0]  k_q, k_d;
  logic [7:0]  drain_q, drain_d;
  logic [5:0]  taps_q, taps_d;
  logic [13:0] bound_q, bound_d;

  logic [13:0] n_clamp;
  logic [5:0]  t_clamp;
  logic        last_tap;

  logic        zapisz_q, zapisz_d;
  logic        rst_cnt_q, rst_cnt_d;
  logic        nowa_q, nowa_d;
  logic [4:0]  a_wsp_q, a_wsp_d;
  logic [12:0] a_x_q, a_x_d;
  logic        mac_clear_q, mac_clear_d;
  logic        mac_en_q, mac_en_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Clamp the run parameters presented with start: N to 8192, T to 1..N_TAPS_MAX.
  always_comb begin
    n_clamp = (ile_probek > N_MAX) ? N_MAX : ile_probek;
    if (ile_wsp == 6'd0)       t_clamp = 6'd1;
    else if (ile_wsp > T_MAX)  t_clamp = T_MAX;
    else                       t_clamp = ile_wsp;
    last_tap = ({1'b0, k_q} == (taps_q - 6'd1));
  end

  // Next-state logic; run parameters are only captured on an accepted start.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    drain_d = drain_q;
    taps_d  = taps_q;
    bound_d = bound_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          taps_d  = t_clamp;
          bound_d = (n_clamp == 14'd0) ? 14'd0 : n_clamp - 14'd1;
          state_d = (n_clamp == 14'd0) ? S_DONE : S_INIT;
        end
      end
      S_INIT:    state_d = S_MAC_CLR;
      S_MAC_CLR: begin
        k_d     = 5'd0;
        state_d = S_MAC;
      end
      S_MAC: begin
        if (last_tap) begin
          drain_d = 8'd0;
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + 5'd1;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = S_WRITE;
        else                       drain_d = drain_q + 8'd1;
      end
      S_WRITE:   if (wynik_ready) state_d = S_NEXT;
      S_NEXT:    state_d = S_CHECK;
      // The counter flag is trusted only here, after NEXT has updated it.
      S_CHECK:   state_d = licznik_full ? S_DONE : S_MAC_CLR;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the next state so they register with it.
  // Taps reaching below sample 0 read zero, so mac_en is gated by k <= address.
  always_comb begin
    zapisz_d    = (state_d == S_INIT);
    rst_cnt_d   = (state_d == S_INIT);
    mac_clear_d = (state_d == S_MAC_CLR);
    mac_en_d    = (state_d == S_MAC) && ({8'd0, k_d} <= A_probki_FIR);
    a_wsp_d     = (state_d == S_MAC) ? k_d : 5'd0;
    a_x_d       = (state_d == S_MAC) ? (A_probki_FIR - {8'd0, k_d}) : 13'd0;
    valid_d     = (state_d == S_WRITE);
    nowa_d      = (state_d == S_NEXT);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  // Control state and run parameters.
  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= 5'd0;
      drain_q <= 8'd0;
      taps_q  <= 6'd1;
      bound_q <= 14'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      drain_q <= drain_d;
      taps_q  <= taps_d;
      bound_q <= bound_d;
    end
  end

  // Registered output strobes and addresses.
  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      zapisz_q    <= 1'b0;
      rst_cnt_q   <= 1'b0;
      nowa_q      <= 1'b0;
      a_wsp_q     <= 5'd0;
      a_x_q       <= 13'd0;
      mac_clear_q <= 1'b0;
      mac_en_q    <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      zapisz_q    <= zapisz_d;
      rst_cnt_q   <= rst_cnt_d;
      nowa_q      <= nowa_d;
      a_wsp_q     <= a_wsp_d;
      a_x_q       <= a_x_d;
      mac_clear_q <= mac_clear_d;
      mac_en_q    <= mac_en_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign FSM_zapisz_probki  = zapisz_q;
  assign FSM_reset_licznik  = rst_cnt_q;
  assign FSM_nowa_probka    = nowa_q;
  assign ile_probek_licznik = bound_q;
  assign A_wsp              = a_wsp_q;
  assign A_x                = a_x_q;
  assign mac_clear          = mac_clear_q;
  assign mac_en             = mac_en_q;
  assign wynik_valid        = valid_q;
  assign busy               = busy_q;
  assign done               = done_q;

endmodule

// File: tb/tb_fir_fsm.sv
// tb_fir_fsm: directed runs of the FIR sequencer against a behavioural sample
// counter. Expected per-result tap patterns are queued at stimulus time and
// checked by an independent monitor when each result is accepted.
module tb_fir_fsm;

  logic        clk_b = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [13:0] ile_probek = '0;
  logic [5:0]  ile_wsp = '0;
  logic [12:0] A_probki_FIR;
  logic        licznik_full;
  logic        FSM_zapisz_probki, FSM_reset_licznik, FSM_nowa_probka;
  logic [13:0] ile_probek_licznik;
  logic [4:0]  A_wsp;
  logic [12:0] A_x;
  logic        mac_clear, mac_en, wynik_valid, busy, done;
  logic        wynik_ready = 1'b1;

  fir_fsm dut (
    .clk_b(clk_b), .rst_n(rst_n), .start(start), .ile_probek(ile_probek),
    .ile_wsp(ile_wsp), .A_probki_FIR(A_probki_FIR), .licznik_full(licznik_full),
    .FSM_zapisz_probki(FSM_zapisz_probki), .FSM_reset_licznik(FSM_reset_licznik),
    .FSM_nowa_probka(FSM_nowa_probka), .ile_probek_licznik(ile_probek_licznik),
    .A_wsp(A_wsp), .A_x(A_x), .mac_clear(mac_clear), .mac_en(mac_en),
    .wynik_valid(wynik_valid), .wynik_ready(wynik_ready), .busy(busy), .done(done)
  );

  always #5 clk_b = ~clk_b;

  // Sample-address counter model sitting downstream of the FSM.
  logic [12:0] cnt_addr, cnt_bound;
  logic        cnt_full;
  always @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      cnt_addr <= '0; cnt_bound <= '0; cnt_full <= 1'b0;
    end else begin
      if (FSM_zapisz_probki) cnt_bound <= ile_probek_licznik[12:0];
      if (FSM_reset_licznik) begin
        cnt_addr <= '0; cnt_full <= 1'b0;
      end else if (FSM_nowa_probka) begin
        if (cnt_addr == cnt_bound) cnt_full <= 1'b1;
        else                       cnt_addr <= cnt_addr + 13'd1;
      end
    end
  end
  assign A_probki_FIR = cnt_addr;
  assign licznik_full = cnt_full;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Expected result: tap window length, mac_en mask over k, sum of A_x over
  // the tap window, and number of cycles wynik_valid stays high.
  typedef struct {
    int          taps;
    logic [31:0] mask;
    int          sum;
    int          vc;
  } exp_t;
  exp_t q[$];

  task automatic push(input int taps, input logic [31:0] mask, input int sum, input int vc);
    exp_t e;
    e.taps = taps; e.mask = mask; e.sum = sum; e.vc = vc;
    q.push_back(e);
  endtask

  // Strobe event counters.
  int c_nowa = 0, c_zap = 0, c_rst = 0, c_done = 0, c_clr = 0;
  initial forever begin
    @(negedge clk_b);
    c_nowa += int'(FSM_nowa_probka);
    c_zap  += int'(FSM_zapisz_probki);
    c_rst  += int'(FSM_reset_licznik);
    c_done += int'(done);
    c_clr  += int'(mac_clear);
  end

  // Monitor: collects the tap window after each mac_clear, checks on accept.
  int          m_idx, m_taps, m_sum, m_vc;
  logic [31:0] m_mask;
  bit          m_win;
  initial begin
    m_win = 0; m_vc = 0; m_idx = 0; m_taps = 0; m_sum = 0; m_mask = '0;
    forever begin
      @(negedge clk_b);
      if (!rst_n) begin
        m_win = 0; m_vc = 0;
      end else begin
        if (m_win) begin
          if (mac_en) m_mask[A_wsp] = 1'b1;
          m_sum += int'(A_x);
          m_idx++;
          if (m_idx >= m_taps) m_win = 0;
        end else if (mac_en) begin
          chk("mac_en outside tap window", 1, 0);
        end
        if (mac_clear) begin
          m_taps = (q.size() > 0) ? q[0].taps : 0;
          m_win  = (m_taps > 0);
          m_idx = 0; m_sum = 0; m_mask = '0;
        end
        if (wynik_valid) m_vc++;
        if (wynik_valid && wynik_ready) begin
          if (q.size() == 0) begin
            chk("unexpected result", 1, 0);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("mac_en mask", longint'(m_mask), longint'(e.mask));
            chk("A_x sum", m_sum, e.sum);
            chk("valid cycles", m_vc, e.vc);
          end
          m_vc = 0;
        end
      end
    end
  end

  // Issue a start with (n, t); returns 1 ns into the cycle after the sampling edge.
  task automatic do_start(input int n, input int t);
    @(posedge clk_b); #1;
    start = 1'b1; ile_probek = 14'(n); ile_wsp = 6'(t);
    @(posedge clk_b); #1;
    start = 1'b0; ile_probek = 14'd5; ile_wsp = 6'd3;
  endtask

  // Count busy cycles (starting from pre) until busy drops, bounded.
  task automatic wait_idle(input int pre, output int cyc);
    bit ok;
    ok = 0; cyc = pre;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk_b);
      if (busy) cyc++;
      else ok = 1;
    end
    if (!ok) chk("timeout waiting for idle", 0, 1);
  endtask

  function automatic longint all_outs();
    return longint'({FSM_zapisz_probki, FSM_reset_licznik, FSM_nowa_probka,
                     ile_probek_licznik, A_wsp, A_x, mac_clear, mac_en,
                     wynik_valid, busy, done});
  endfunction

  initial begin
    int cyc, b_nowa, b_done, b_zap, b_rst, b_clr;
    bit seen;

    // Reset state
    #12;
    chk("outputs in reset", all_outs(), 0);
    @(posedge clk_b); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk_b);
    #1 chk("outputs after reset", all_outs(), 0);

    // N=3, T=4 with ready high
    push(4, 32'h1, 24570, 1);
    push(4, 32'h3, 16382, 1);
    push(4, 32'h7, 8194, 1);
    b_nowa = c_nowa; b_done = c_done;
    do_start(3, 4);
    chk("INIT strobes at t+1", {FSM_zapisz_probki, FSM_reset_licznik}, 2'b11);
    chk("counter bound N-1", ile_probek_licznik, 2);
    @(posedge clk_b); #1 chk("mac_clear at t+2", mac_clear, 1);
    @(posedge clk_b); #1 chk("mac_en at t+3", mac_en, 1);
    wait_idle(2, cyc);
    chk("run N3T4 busy cycles", cyc, 32);
    chk("run N3T4 nowa pulses", c_nowa - b_nowa, 3);
    chk("run N3T4 done pulses", c_done - b_done, 1);
    chk("run N3T4 results left", q.size(), 0);

    // Second run with the counter's full flag still set from the first
    push(3, 32'h1, 16381, 1);
    push(3, 32'h3, 8192, 1);
    b_nowa = c_nowa; b_done = c_done;
    do_start(2, 3);
    wait_idle(0, cyc);
    chk("stale-full run busy cycles", cyc, 20);
    chk("stale-full run nowa pulses", c_nowa - b_nowa, 2);
    chk("stale-full run results left", q.size(), 0);
    chk("stale-full run done pulses", c_done - b_done, 1);

    // N=0: done immediately, no counter strobes
    b_nowa = c_nowa; b_zap = c_zap; b_rst = c_rst; b_clr = c_clr; b_done = c_done;
    do_start(0, 4);
    chk("N0 done at t+1", {done, busy}, 2'b11);
    wait_idle(0, cyc);
    chk("N0 busy cycles", cyc, 1);
    chk("N0 counter strobes", (c_nowa - b_nowa) + (c_zap - b_zap) + (c_rst - b_rst) + (c_clr - b_clr), 0);
    chk("N0 done pulses", c_done - b_done, 1);

    // T=0 behaves as one tap
    push(1, 32'h1, 0, 1);
    do_start(1, 0);
    wait_idle(0, cyc);
    chk("T0 busy cycles", cyc, 9);
    chk("T0 results left", q.size(), 0);

    // T=40 clamps to 32 taps
    push(32, 32'h1, 253456, 1);
    do_start(1, 40);
    wait_idle(0, cyc);
    chk("T40 busy cycles", cyc, 40);
    chk("T40 results left", q.size(), 0);

    // Handshake: ready low for the first 5 valid cycles
    push(2, 32'h1, 8191, 6);
    b_nowa = c_nowa; b_done = c_done;
    wynik_ready = 1'b0;
    do_start(1, 2);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_b);
      if (wynik_valid) seen = 1;
    end
    chk("valid appeared", seen, 1);
    repeat (4) @(negedge clk_b);
    chk("valid held while not ready", wynik_valid, 1);
    chk("no nowa before accept", c_nowa - b_nowa, 0);
    @(posedge clk_b); #1 wynik_ready = 1'b1;
    wait_idle(0, cyc);
    chk("handshake nowa pulses", c_nowa - b_nowa, 1);
    chk("handshake done pulses", c_done - b_done, 1);
    chk("handshake results left", q.size(), 0);

    // N=9000 clamps; reset mid-MAC aborts the run
    push(8, 32'h1, 0, 1);
    do_start(9000, 8);
    chk("N9000 counter bound", ile_probek_licznik, 8191);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_b);
      if (mac_en) seen = 1;
    end
    chk("mac_en seen before reset", seen, 1);
    #2 rst_n = 1'b0;
    #1 chk("outputs on async reset", all_outs(), 0);
    q.delete();
    repeat (2) @(posedge clk_b);
    #1 rst_n = 1'b1;
    b_zap = c_zap; b_clr = c_clr;
    repeat (10) @(posedge clk_b);
    #1 chk("no strobes after reset w/o start", (c_zap - b_zap) + (c_clr - b_clr) + int'(busy), 0);

    // start pulsed while busy is ignored
    push(1, 32'h1, 0, 1);
    push(1, 32'h1, 1, 1);
    b_done = c_done; b_nowa = c_nowa;
    do_start(2, 1);
    @(posedge clk_b); #1 start = 1'b1; ile_probek = 14'd5; ile_wsp = 6'd3;
    @(posedge clk_b); #1 start = 1'b0;
    wait_idle(2, cyc);
    chk("busy-start run busy cycles", cyc, 16);
    chk("busy-start run nowa pulses", c_nowa - b_nowa, 2);
    repeat (5) @(posedge clk_b);
    #1 chk("busy-start not queued", busy, 0);
    chk("busy-start done pulses", c_done - b_done, 1);
    chk("busy-start results left", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fir_fsm.md
# fir_fsm

Control state machine for the FIR engine on `clk_b`. It sequences one filtering run: it arms and drives the sample-address counter, sweeps the coefficient taps for each sample, and controls the MAC datapath. It hands each result downstream with a valid/ready handshake and signals completion to the register block. It sits directly upstream of the sample counter and consumes that counter's address and full flag.

## Interface
Parameters:
- `N_TAPS_MAX`, 32: maximum tap count; the tap counter is 5 bits.
- `MAC_LAT`, 2: MAC pipeline depth, in cycles from the last `mac_en` to the result being valid.

Ports:
- `clk_b`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  run request; honoured only in IDLE.
- `ile_probek`  in  14  sample count N for the run.
- `ile_wsp`  in  6  tap count T for the run.
- `A_probki_FIR`  in  13  current sample address from the counter.
- `licznik_full`  in  1  counter-exhausted flag.
- `FSM_zapisz_probki`  out  1  pulse: counter latches its bound.
- `FSM_reset_licznik`  out  1  pulse: counter clears to 0.
- `FSM_nowa_probka`  out  1  pulse: counter advances.
- `ile_probek_licznik`  out  14  bound for the counter, equal to N−1.
- `A_wsp`  out  5  coefficient memory address, equal to k.
- `A_x`  out  13  sample memory address, `A_probki_FIR − k` (mod 2^13).
- `mac_clear`  out  1  clears the accumulator.
- `mac_en`  out  1  accumulate `coef[A_wsp] * x[A_x]`.
- `wynik_valid`  out  1  result available.
- `wynik_ready`  in  1  downstream accepts the result.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of a run.

## Operation
- All outputs are registered (Moore). Reset value of every output is 0, including `ile_probek_licznik`. State resets to IDLE.
- Run parameters are latched on accepted `start`:
  - N is clamped to 8192.
  - T is clamped to 1..N_TAPS_MAX; T=0 becomes 1.
  - `ile_probek_licznik` = N−1.
  - Parameter changes during a run are ignored.
- States:
  - IDLE: if `start`=1 and N=0, go to DONE. If `start`=1 and N≥1, go to INIT.
  - INIT (1 cycle): assert `FSM_zapisz_probki` and `FSM_reset_licznik` together, then go to MAC_CLR.
  - MAC_CLR (1 cycle): assert `mac_clear`, set k=0, then go to MAC.
  - MAC (T cycles, k=0..T−1): drive `A_wsp`=k and `A_x`.
    - `mac_en`=1 only when k ≤ `A_probki_FIR`. Earlier samples below index 0 count as zero, so their taps are skipped with `mac_en`=0.
    - After k=T−1, go to DRAIN.
  - DRAIN (MAC_LAT cycles): no strobes, then go to WRITE.
  - WRITE: hold `wynik_valid`=1 until a cycle with `wynik_ready`=1. `wynik_valid` drops the next cycle, then go to NEXT.
  - NEXT (1 cycle): assert `FSM_nowa_probka`, then go to CHECK.
  - CHECK (1 cycle): sample `licznik_full`, which the counter updated at the end of NEXT. If 1, go to DONE; otherwise go to MAC_CLR.
  - DONE (1 cycle): assert `done`, then go to IDLE.
- `licznik_full` is read only in CHECK. A stale value left over from a previous run must not affect INIT or MAC.
- Samples processed are at addresses 0..N−1, exactly N results per run.
- `start` while `busy`=1 is ignored. It is not queued.
- Asserting `rst_n`=0 mid-run forces IDLE asynchronously and zeroes all outputs. Any partial result is discarded.

## Timing
- `start` sampled at edge t: INIT strobes during cycle t+1, `mac_clear` during t+2, first `mac_en` during t+3.
- Cycles per sample = 1 (MAC_CLR) + T + MAC_LAT + W + 1 (NEXT) + 1 (CHECK), where W ≥ 1 is the number of WRITE cycles.
- With `wynik_ready` tied high and defaults (MAC_LAT=2): one sample costs T+6 cycles.
- N=0: `done` pulses in cycle t+1. No counter strobes are issued.
- `done` and `busy` never overlap IDLE: `busy`=1 during DONE and 0 the cycle after.
- `A_x` wrap-around (k > `A_probki_FIR`) is permitted because `mac_en`=0 on those taps.

## Test plan
- Reset with `wynik_ready`=1: all outputs 0, `busy`=0. `start` with N=3, T=4: exactly 3 `wynik_valid` pulses. `FSM_nowa_probka` pulses 3 times. `done` follows the third CHECK. Total run ≈ 3×10 + 2 cycles.
- N=3, T=4, per-sample `mac_en` counts 1, 2, 3. `A_x` sequence for sample 2 is 2, 1, 0, 8191 with `mac_en`=1,1,1,0.
- Handshake: `wynik_ready` held low for 5 cycles, so `wynik_valid` stays high 6 cycles. No `FSM_nowa_probka` until acceptance.
- N=0 → `done` at t+1 with no counter strobes. T=0 → exactly 1 MAC cycle. T=40 → 32 MAC cycles. N=9000 → `ile_probek_licznik`=8191.
- Second run after a completed run (counter `licznik_full` still 1): `start` again with N=2. Exactly 2 results; the stale flag is ignored.
- `rst_n` low mid-MAC: all outputs 0 immediately and state IDLE. After release, `start` is required before any strobe. `start` pulsed while busy has no effect.
